// File: rtl/comparator_arbiter_pkg.sv
// Shared compare definitions: operand width, select codes and arbiter states.
package comparator_arbiter_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned CMP_SEL_WIDTH = 3;

    localparam logic [CMP_SEL_WIDTH:0] CMP_SEL_EQ  = 4'd0;
    localparam logic [CMP_SEL_WIDTH:0] CMP_SEL_NE  = 4'd1;
    localparam logic [CMP_SEL_WIDTH:0] CMP_SEL_LT  = 4'd2;
    localparam logic [CMP_SEL_WIDTH:0] CMP_SEL_GE  = 4'd3;
    localparam logic [CMP_SEL_WIDTH:0] CMP_SEL_LTU = 4'd4;
    localparam logic [CMP_SEL_WIDTH:0] CMP_SEL_GEU = 4'd5;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_COMPARE = 2'd1,
        ARB_RESPOND = 2'd2
    } arb_state_t;

endpackage

// File: rtl/comparator_unit.sv
// Combinational comparator; signedness comes from the select code, output is 0 when disabled.
module comparator_unit
    import comparator_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = comparator_arbiter_pkg::XLEN
) (
    input  logic                     i_Enable,
    input  logic [XLEN-1:0]          i_A,
    input  logic [XLEN-1:0]          i_B,
    input  logic [CMP_SEL_WIDTH:0]   i_Select,
    output logic                     o_Result
);

    always_comb begin
        o_Result = 1'b0;
        if (i_Enable) begin
            case (i_Select)
                CMP_SEL_EQ:  o_Result = (i_A == i_B);
                CMP_SEL_NE:  o_Result = (i_A != i_B);
                CMP_SEL_LT:  o_Result = ($signed(i_A) <  $signed(i_B));
                CMP_SEL_GE:  o_Result = ($signed(i_A) >= $signed(i_B));
                CMP_SEL_LTU: o_Result = (i_A <  i_B);
                CMP_SEL_GEU: o_Result = (i_A >= i_B);
                default:     o_Result = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/comparator_arbiter.sv
// Round-robin arbiter sharing one comparator_unit between branch resolution (0) and SLT/SLTU (1).
module comparator_arbiter
    import comparator_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = comparator_arbiter_pkg::XLEN
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset_N,
    input  logic                     i_Req0_Valid,
    output logic                     o_Req0_Ready,
    input  logic [XLEN-1:0]          i_Req0_A,
    input  logic [XLEN-1:0]          i_Req0_B,
    input  logic [CMP_SEL_WIDTH:0]   i_Req0_Select,
    input  logic                     i_Req1_Valid,
    output logic                     o_Req1_Ready,
    input  logic [XLEN-1:0]          i_Req1_A,
    input  logic [XLEN-1:0]          i_Req1_B,
    input  logic [CMP_SEL_WIDTH:0]   i_Req1_Select,
    output logic                     o_Resp0_Valid,
    input  logic                     i_Resp0_Ready,
    output logic                     o_Resp0_Result,
    output logic                     o_Resp1_Valid,
    input  logic                     i_Resp1_Ready,
    output logic                     o_Resp1_Result
);

    arb_state_t               state_q, state_d;
    logic [XLEN-1:0]          a_q, b_q;
    logic [CMP_SEL_WIDTH:0]   sel_q;
    logic                     result_q;
    logic                     grant_q;
    logic                     last_q;
    logic                     grant_d;
    logic                     req_fire;
    logic                     resp_fire;
    logic                     cmp_en;
    logic                     cmp_out;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_d = i_Req1_Valid;
        if (i_Req0_Valid && i_Req1_Valid) begin
            grant_d = ~last_q;
        end
    end

    assign o_Req0_Ready = (state_q == ARB_IDLE) && !grant_d && i_Req0_Valid;
    assign o_Req1_Ready = (state_q == ARB_IDLE) &&  grant_d && i_Req1_Valid;
    assign req_fire     = o_Req0_Ready || o_Req1_Ready;
    assign resp_fire    = (state_q == ARB_RESPOND) && (grant_q ? i_Resp1_Ready : i_Resp0_Ready);
    assign cmp_en       = (state_q == ARB_COMPARE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:    if (req_fire)  state_d = ARB_COMPARE;
            ARB_COMPARE: state_d = ARB_RESPOND;
            ARB_RESPOND: if (resp_fire) state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state_q  <= ARB_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            result_q <= 1'b0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                a_q     <= grant_d ? i_Req1_A      : i_Req0_A;
                b_q     <= grant_d ? i_Req1_B      : i_Req0_B;
                sel_q   <= grant_d ? i_Req1_Select : i_Req0_Select;
                grant_q <= grant_d;
                last_q  <= grant_d;
            end
            if (cmp_en) begin
                result_q <= cmp_out;
            end
        end
    end

    comparator_unit #(
        .XLEN(XLEN)
    ) u_comparator_unit (
        .i_Enable (cmp_en),
        .i_A      (a_q),
        .i_B      (b_q),
        .i_Select (sel_q),
        .o_Result (cmp_out)
    );

    assign o_Resp0_Valid  = (state_q == ARB_RESPOND) && !grant_q;
    assign o_Resp1_Valid  = (state_q == ARB_RESPOND) &&  grant_q;
    assign o_Resp0_Result = o_Resp0_Valid && result_q;
    assign o_Resp1_Result = o_Resp1_Valid && result_q;

endmodule
